// File: rtl/display_clk_pkg.sv
// display_clk_pkg: shared state encoding and output count widths for the display clock supervisor
package display_clk_pkg;
  typedef enum logic [2:0] {RESET, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  localparam int RETRY_W = 4;
  localparam int LOSS_W = 8;
endpackage

// File: rtl/display_clock_supervisor_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser, async active-low reset to 0
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end
  assign o_q = sync_q;
endmodule

// File: rtl/display_clock_supervisor.sv
// display_clock_supervisor: MMCM reset/lock supervision with timeout, bounded retries and loss detection.
// Define DISPLAY_CLK_SUP_STATS_EN to implement the run-time lock-loss counter on o_loss_count.
module display_clock_supervisor
  import display_clk_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_locked,
  input  logic               i_restart,
  output logic               o_mmcm_rst,
  output logic               o_clk_ok,
  output logic               o_fault,
  output logic [RETRY_W-1:0] o_retry_count,
  output logic [LOSS_W-1:0]  o_loss_count
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);
  state_t state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic mmcm_rst_q, mmcm_rst_d, clk_ok_q, clk_ok_d, fault_q, fault_d;
  logic lk, waiting, timeout;
  sync_2ff #(.W(1)) u_lock_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_locked),
    .o_q    (lk)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= RESET;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stb_cnt_q  <= '0;
      retry_q    <= '0;
      mmcm_rst_q <= 1'b1;
      clk_ok_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= mmcm_rst_d;
      clk_ok_q   <= clk_ok_d;
      fault_q    <= fault_d;
    end
  end
  always_comb begin
    waiting   = state_q == WAIT_LOCK || state_q == STABLE;
    timeout   = waiting && to_cnt_q == TO_LAST;
    retry_inc = &retry_q ? retry_q : retry_q + 1'b1;
    state_d   = i_restart ? RESET :
                timeout ? ((MAX_RETRIES != 0 && retry_inc >= MAX_R) ? FAULT : RESET) :
                state_q == RESET ? (rst_cnt_q == RST_LAST ? WAIT_LOCK : RESET) :
                state_q == WAIT_LOCK ? (lk ? STABLE : WAIT_LOCK) :
                state_q == STABLE ? (!lk ? WAIT_LOCK : stb_cnt_q == STB_LAST ? RUN : STABLE) :
                state_q == RUN ? (lk ? RUN : RESET) : FAULT;
  end
  // Outputs are registered from the next state so they move together with the state register.
  always_comb begin
    rst_cnt_d  = (state_q == RESET && !i_restart) ? rst_cnt_q + 1'b1 : '0;
    to_cnt_d   = (state_d == WAIT_LOCK || state_d == STABLE) ?
                 (state_q == RESET ? '0 : to_cnt_q + 1'b1) : '0;
    stb_cnt_d  = (state_q == STABLE && state_d == STABLE) ? stb_cnt_q + 1'b1 : '0;
    retry_d    = i_restart ? '0 :
                 timeout ? retry_inc :
                 (state_q == STABLE && state_d == RUN) ? '0 : retry_q;
    mmcm_rst_d = state_d == RESET || state_d == FAULT;
    clk_ok_d   = state_d == RUN;
    fault_d    = state_d == FAULT;
  end
  assign o_mmcm_rst    = mmcm_rst_q;
  assign o_clk_ok      = clk_ok_q;
  assign o_fault       = fault_q;
  assign o_retry_count = retry_q;
`ifdef DISPLAY_CLK_SUP_STATS_EN
  logic [LOSS_W-1:0] loss_q, loss_d;
  always_comb
    loss_d = (state_q == RUN && state_d == RESET && !i_restart && !(&loss_q)) ? loss_q + 1'b1 : loss_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) loss_q <= '0;
    else          loss_q <= loss_d;
  end
  assign o_loss_count = loss_q;
`else
  assign o_loss_count = '0;
`endif
endmodule

// File: tb/tb_display_clock_supervisor.sv
// tb_display_clock_supervisor: directed cycle-accurate bench for bring-up, timeout/fault, glitch, loss, restart and async reset
module tb_display_clock_supervisor;
  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0, restart = 1'b0;
  logic mmcm_rst, clk_ok, fault;
  logic [3:0] retry;
  logic [7:0] loss;
  int cyc = 0, n_checks = 0, n_errors = 0;
`ifdef DISPLAY_CLK_SUP_STATS_EN
  localparam logic [7:0] LOSS1 = 8'd1;
`else
  localparam logic [7:0] LOSS1 = 8'd0;
`endif
  display_clock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_locked     (locked),
    .i_restart    (restart),
    .o_mmcm_rst   (mmcm_rst),
    .o_clk_ok     (clk_ok),
    .o_fault      (fault),
    .o_retry_count(retry),
    .o_loss_count (loss)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mmcm", mmcm_rst, 1);
    chk("rst_clk_ok", clk_ok, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry, 0);
    chk("rst_loss", loss, 0);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k <= 4; k++) begin
      go_to(k);
      chk("bringup_pulse", mmcm_rst, k < 4);
    end
    go_to(10); locked = 1'b1;
    go_to(20); chk("bringup_ok_early", clk_ok, 0);
    go_to(21); chk("bringup_ok", clk_ok, 1); chk("bringup_retry", retry, 0); chk("bringup_mmcm", mmcm_rst, 0);
    go_to(23); locked = 1'b0;
    go_to(25); chk("loss_ok_hold", clk_ok, 1);
    go_to(26); chk("loss_ok_fall", clk_ok, 0); chk("loss_mmcm", mmcm_rst, 1);
    chk("loss_count", loss, LOSS1); chk("loss_retry", retry, 0);
    go_to(29); chk("loss_pulse_end", mmcm_rst, 1);
    go_to(30); chk("loss_pulse_done", mmcm_rst, 0);
    go_to(50); chk("to1_before", mmcm_rst, 0); chk("to1_retry_before", retry, 0);
    go_to(51); chk("to1_mmcm", mmcm_rst, 1); chk("to1_retry", retry, 1); chk("to1_fault", fault, 0);
    go_to(54); chk("to1_pulse_end", mmcm_rst, 1);
    go_to(55); chk("to1_pulse_done", mmcm_rst, 0);
    go_to(75); chk("to2_before", mmcm_rst, 0); chk("to2_fault_before", fault, 0);
    go_to(76); chk("to2_fault", fault, 1); chk("to2_mmcm", mmcm_rst, 1); chk("to2_retry", retry, 2);
    go_to(86); chk("fault_sticky", fault, 1); chk("fault_mmcm", mmcm_rst, 1);
    restart = 1'b1;
    go_to(87); restart = 1'b0;
    chk("rs_fault", fault, 0); chk("rs_retry", retry, 0); chk("rs_mmcm", mmcm_rst, 1); chk("rs_ok", clk_ok, 0);
    go_to(90); chk("rs_pulse_end", mmcm_rst, 1);
    go_to(91); chk("rs_pulse_done", mmcm_rst, 0); locked = 1'b1;
    go_to(96); locked = 1'b0;
    go_to(97); locked = 1'b1;
    go_to(107); chk("glitch_ok_early", clk_ok, 0); chk("glitch_no_pulse", mmcm_rst, 0);
    go_to(108); chk("glitch_ok", clk_ok, 1); chk("glitch_retry", retry, 0); chk("glitch_loss", loss, LOSS1);
    go_to(110); locked = 1'b0;
    go_to(112); chk("rsloss_ok_hold", clk_ok, 1); restart = 1'b1;
    go_to(113); restart = 1'b0;
    chk("rsloss_ok", clk_ok, 0); chk("rsloss_mmcm", mmcm_rst, 1); chk("rsloss_loss", loss, LOSS1);
    locked = 1'b1;
    go_to(125); chk("rerun_early", clk_ok, 0);
    go_to(126); chk("rerun_ok", clk_ok, 1);
    go_to(128);
    rst_n = 1'b0;
    #1;
    chk("arst_ok", clk_ok, 0); chk("arst_mmcm", mmcm_rst, 1); chk("arst_retry", retry, 0);
    chk("arst_loss", loss, 0); chk("arst_fault", fault, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
